// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential/branch/jump/call/return PC update
// with a small return-address stack and a sticky RUN -> HALT state.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH  = 12,
    parameter int unsigned IMM_WIDTH = 8,
    parameter int unsigned RAS_DEPTH = 4,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic                         halt_req,
    input  logic                         branch_en,
    input  logic                         zero,
    input  logic [IMM_WIDTH-1:0]         imm,
    input  logic                         jump_en,
    input  logic                         call_en,
    input  logic                         ret_en,
    input  logic [PC_WIDTH-1:0]          jump_target,
    output logic [PC_WIDTH-1:0]          pc,
    output logic                         halted,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [PC_WIDTH-1:0]          pc_d;
    logic [PC_WIDTH-1:0]          pc_inc;
    logic [PC_WIDTH-1:0]          branch_tgt;
    logic [CNT_W-1:0]             cnt_d;
    logic                         ovf_d;
    logic                         unf_d;
    logic                         push;
    logic                         advance;
    logic                         stack_full;
    logic                         stack_empty;
    logic [PTR_W-1:0]             push_idx;
    logic [PTR_W-1:0]             top_idx;
    logic signed [IMM_WIDTH-1:0]  imm_s;
    logic [PC_WIDTH-1:0]          ras_mem [RAS_DEPTH];

    assign imm_s       = imm;
    assign pc_inc      = pc + PC_WIDTH'(1);
    assign branch_tgt  = pc + PC_WIDTH'(imm_s);
    assign stack_full  = (ras_count == CNT_W'(RAS_DEPTH));
    assign stack_empty = (ras_count == '0);
    assign push_idx    = PTR_W'(ras_count);
    assign top_idx     = PTR_W'(ras_count - CNT_W'(1));
    assign halted      = (state_q == ST_HALT);

    // State register: reset always returns to RUN.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: halt_req moves RUN to HALT; HALT only leaves via reset.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN && halt_req) begin
            state_d = ST_HALT;
        end
    end

    // Action decode: priority ret > call > jump > taken branch > sequential.
    always_comb begin
        pc_d    = pc;
        cnt_d   = ras_count;
        ovf_d   = ras_overflow;
        unf_d   = ras_underflow;
        push    = 1'b0;
        advance = (state_q == ST_RUN) && !halt_req && !stall;
        if (advance) begin
            if (ret_en) begin
                if (stack_empty) begin
                    pc_d  = pc_inc;
                    unf_d = 1'b1;
                end else begin
                    pc_d  = ras_mem[top_idx];
                    cnt_d = ras_count - CNT_W'(1);
                end
            end else if (call_en) begin
                pc_d = jump_target;
                if (stack_full) begin
                    ovf_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    cnt_d = ras_count + CNT_W'(1);
                end
            end else if (jump_en) begin
                pc_d = jump_target;
            end else if (branch_en && zero) begin
                pc_d = branch_tgt;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    // PC, stack depth and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= PC_WIDTH'(RESET_PC);
            ras_count     <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            pc            <= pc_d;
            ras_count     <= cnt_d;
            ras_overflow  <= ovf_d;
            ras_underflow <= unf_d;
        end
    end

    // Stack storage is never cleared; ras_count alone marks valid entries.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            ras_mem[push_idx] <= pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven bench for pc_sequencer with an expected-result queue.
module tb_pc_sequencer;

    localparam logic [7:0] R = 8'h80;  // reset
    localparam logic [7:0] S = 8'h40;  // stall
    localparam logic [7:0] H = 8'h20;  // halt_req
    localparam logic [7:0] B = 8'h10;  // branch_en
    localparam logic [7:0] Z = 8'h08;  // zero
    localparam logic [7:0] C = 8'h04;  // call_en
    localparam logic [7:0] T = 8'h02;  // ret_en
    localparam logic [7:0] J = 8'h01;  // jump_en

    typedef struct {
        logic [7:0]  ctl;
        logic [7:0]  imm;
        logic [11:0] jt;
        logic [11:0] e_pc;
        logic        e_halt;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, stall, halt_req, branch_en, zero, jump_en, call_en, ret_en;
    logic [7:0]  imm;
    logic [11:0] jump_target;
    logic [11:0] pc;
    logic        halted;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int   checks   = 0;
    int   failures = 0;
    int   step     = 0;
    vec_t tbl[$];
    vec_t sb[$];

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall), .halt_req(halt_req),
        .branch_en(branch_en), .zero(zero), .imm(imm), .jump_en(jump_en),
        .call_en(call_en), .ret_en(ret_en), .jump_target(jump_target),
        .pc(pc), .halted(halted), .ras_count(ras_count),
        .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] ctl, input logic [7:0] im,
                                input logic [11:0] jt, input logic [11:0] epc,
                                input logic eh, input logic [2:0] ec,
                                input logic eo, input logic eu);
        vec_t v;
        v.ctl = ctl; v.imm = im; v.jt = jt; v.e_pc = epc;
        v.e_halt = eh; v.e_cnt = ec; v.e_ovf = eo; v.e_unf = eu;
        return v;
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0d exp=%0d", nm, step, got, exp);
        end
    endtask

    // Drive one vector, queue its expectation, compare after the edge.
    task automatic apply(input vec_t v);
        vec_t e;
        reset       = v.ctl[7];
        stall       = v.ctl[6];
        halt_req    = v.ctl[5];
        branch_en   = v.ctl[4];
        zero        = v.ctl[3];
        call_en     = v.ctl[2];
        ret_en      = v.ctl[1];
        jump_en     = v.ctl[0];
        imm         = v.imm;
        jump_target = v.jt;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("pc",            int'(pc),            int'(e.e_pc));
        chk("halted",        int'(halted),        int'(e.e_halt));
        chk("ras_count",     int'(ras_count),     int'(e.e_cnt));
        chk("ras_overflow",  int'(ras_overflow),  int'(e.e_ovf));
        chk("ras_underflow", int'(ras_underflow), int'(e.e_unf));
        step++;
    endtask

    initial begin
        // reset, backward branch taken / not taken
        tbl.push_back(mk(R,       8'h00, 12'd0,   12'd0,    0, 0, 0, 0));
        tbl.push_back(mk(J,       8'h00, 12'd10,  12'd10,   0, 0, 0, 0));
        tbl.push_back(mk(B|Z,     8'hFD, 12'd0,   12'd7,    0, 0, 0, 0));
        tbl.push_back(mk(J,       8'h00, 12'd10,  12'd10,   0, 0, 0, 0));
        tbl.push_back(mk(B,       8'hFD, 12'd0,   12'd11,   0, 0, 0, 0));
        // nested call / return
        tbl.push_back(mk(J,       8'h00, 12'd5,   12'd5,    0, 0, 0, 0));
        tbl.push_back(mk(C,       8'h00, 12'd100, 12'd100,  0, 1, 0, 0));
        tbl.push_back(mk(C,       8'h00, 12'd200, 12'd200,  0, 2, 0, 0));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd101,  0, 1, 0, 0));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd6,    0, 0, 0, 0));
        // call+ret together: only the return runs
        tbl.push_back(mk(C|T,     8'h00, 12'd300, 12'd7,    0, 0, 0, 1));
        tbl.push_back(mk(R|J,     8'h00, 12'd99,  12'd0,    0, 0, 0, 0));
        tbl.push_back(mk(C,       8'h00, 12'd50,  12'd50,   0, 1, 0, 0));
        tbl.push_back(mk(C|T,     8'h00, 12'd300, 12'd1,    0, 0, 0, 0));
        // stall beats jump; branch offset extremes and wrap; jump beats branch
        tbl.push_back(mk(S|J,     8'h00, 12'd77,  12'd1,    0, 0, 0, 0));
        tbl.push_back(mk(B|Z,     8'h7F, 12'd0,   12'd128,  0, 0, 0, 0));
        tbl.push_back(mk(B|Z,     8'h80, 12'd0,   12'd0,    0, 0, 0, 0));
        tbl.push_back(mk(B|Z,     8'hFF, 12'd0,   12'd4095, 0, 0, 0, 0));
        tbl.push_back(mk(8'h00,   8'h00, 12'd0,   12'd0,    0, 0, 0, 0));
        tbl.push_back(mk(J|B|Z,   8'h05, 12'd33,  12'd33,   0, 0, 0, 0));
        tbl.push_back(mk(J,       8'h00, 12'd0,   12'd0,    0, 0, 0, 0));
        // overflow then underflow, LIFO order
        tbl.push_back(mk(C,       8'h00, 12'd30,  12'd30,   0, 1, 0, 0));
        tbl.push_back(mk(C,       8'h00, 12'd40,  12'd40,   0, 2, 0, 0));
        tbl.push_back(mk(C,       8'h00, 12'd50,  12'd50,   0, 3, 0, 0));
        tbl.push_back(mk(C,       8'h00, 12'd60,  12'd60,   0, 4, 0, 0));
        tbl.push_back(mk(C,       8'h00, 12'd70,  12'd70,   0, 4, 1, 0));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd51,   0, 3, 1, 0));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd41,   0, 2, 1, 0));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd31,   0, 1, 1, 0));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd1,    0, 0, 1, 0));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd2,    0, 0, 1, 1));
        // reset while stalled
        tbl.push_back(mk(R|S,     8'h00, 12'd0,   12'd0,    0, 0, 0, 0));
        // build count=3 with both flags, then halt with stall+ret pending
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd1,    0, 0, 0, 1));
        tbl.push_back(mk(C,       8'h00, 12'd30,  12'd30,   0, 1, 0, 1));
        tbl.push_back(mk(C,       8'h00, 12'd40,  12'd40,   0, 2, 0, 1));
        tbl.push_back(mk(C,       8'h00, 12'd50,  12'd50,   0, 3, 0, 1));
        tbl.push_back(mk(C,       8'h00, 12'd60,  12'd60,   0, 4, 0, 1));
        tbl.push_back(mk(C,       8'h00, 12'd70,  12'd70,   0, 4, 1, 1));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd51,   0, 3, 1, 1));
        tbl.push_back(mk(H|S|T|J, 8'h00, 12'd9,   12'd51,   1, 3, 1, 1));
        // HALT ignores everything
        tbl.push_back(mk(J,       8'h00, 12'd9,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(C,       8'h00, 12'd9,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(T,       8'h00, 12'd0,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(B|Z,     8'h03, 12'd0,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(S,       8'h00, 12'd0,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(8'h00,   8'h00, 12'd0,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(C|T,     8'h00, 12'd9,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(J|S,     8'h00, 12'd9,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(H,       8'h00, 12'd0,   12'd51,   1, 3, 1, 1));
        tbl.push_back(mk(B|Z|C,   8'hF0, 12'd9,   12'd51,   1, 3, 1, 1));
        // reset overrides halt/jump, then sequential restarts at RESET_PC
        tbl.push_back(mk(R|H|J,   8'h00, 12'd9,   12'd0,    0, 0, 0, 0));
        tbl.push_back(mk(8'h00,   8'h00, 12'd0,   12'd1,    0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // full sequential wrap from reset
        apply(mk(R, 8'h00, 12'd0, 12'd0, 0, 0, 0, 0));
        for (int i = 0; i < 4096; i++) begin
            apply(mk(8'h00, 8'h00, 12'd0, 12'((i + 1) % 4096), 0, 0, 0, 0));
        end

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
